pattern_count_top: RTL and testbench

Top-level block for program 3. It searches a 256-bit message held in data memory for a 5-bit pattern and writes three counts back into data memory. The block is a hardwired FSM wrapped around its data memory instance. The bench backdoor-loads memory, pulses `reset` to start the run, and waits for `done`.

---
 rtl/pattern_count_top.sv | 188 ++++++++++++++++++
 tb/tb_pattern_count_top.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pattern_count_top.sv
// Program 3: scans a 256-bit message in data memory for a 5-bit pattern
// and writes the in-byte count, the byte-occurrence count and the full-string count back to memory.

module pattern_count_dm (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);
    logic [7:0] core [0:255];

    assign rdata_o = core[raddr_i];

    // Synchronous write port; no reset so contents survive run restarts
    always_ff @(posedge clk) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end
endmodule

module pattern_count_top (
    input  logic clk,
    input  logic reset,
    output logic done
);
    typedef enum logic [3:0] {
        LOAD_PAT   = 4'd0,
        LOAD_FIRST = 4'd1,
        SCAN       = 4'd2,
        TAIL       = 4'd3,
        WR33       = 4'd4,
        WR34       = 4'd5,
        WR35       = 4'd6,
        DONE       = 4'd7
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;
    logic [7:0] prev_q, prev_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] ctb_q, ctb_d;
    logic [7:0] cto_q, cto_d;
    logic [7:0] cts_q, cts_d;
    logic       done_q, done_d;

    logic       we_s;
    logic [7:0] waddr_s;
    logic [7:0] wdata_s;
    logic [7:0] raddr_s;
    logic [7:0] rdata_s;
    logic [2:0] inb_s;
    logic [2:0] crs_s;

    // Matches of the four windows lying wholly inside one byte
    function automatic logic [2:0] inbyte_hits(input logic [7:0] b, input logic [4:0] p);
        inbyte_hits = {2'b00, (b[7:3] == p)} + {2'b00, (b[6:2] == p)}
                    + {2'b00, (b[5:1] == p)} + {2'b00, (b[4:0] == p)};
    endfunction

    // Matches of the four windows straddling the hi/lo byte boundary
    function automatic logic [2:0] cross_hits(input logic [7:0] hi, input logic [7:0] lo,
                                              input logic [4:0] p);
        logic [15:0] w;
        w = {hi, lo};
        cross_hits = {2'b00, (w[11:7] == p)} + {2'b00, (w[10:6] == p)}
                   + {2'b00, (w[9:5] == p)}  + {2'b00, (w[8:4] == p)};
    endfunction

    pattern_count_dm dm1 (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (wdata_s),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

    assign inb_s = inbyte_hits(prev_q, pat_q);
    assign crs_s = cross_hits(prev_q, rdata_s, pat_q);
    assign done  = done_q;

    // State and datapath registers; reset doubles as the start request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_PAT;
            pat_q   <= 5'd0;
            prev_q  <= 8'd0;
            idx_q   <= 5'd0;
            ctb_q   <= 8'd0;
            cto_q   <= 8'd0;
            cts_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter update and memory port control
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        ctb_d   = ctb_q;
        cto_d   = cto_q;
        cts_d   = cts_q;
        done_d  = done_q;
        we_s    = 1'b0;
        waddr_s = 8'd33;
        wdata_s = ctb_q;
        raddr_s = 8'd32;

        case (state_q)
            LOAD_PAT: begin
                raddr_s = 8'd32;
                pat_d   = rdata_s[7:3];
                ctb_d   = 8'd0;
                cto_d   = 8'd0;
                cts_d   = 8'd0;
                done_d  = 1'b0;
                state_d = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                raddr_s = 8'd0;
                prev_d  = rdata_s;
                idx_d   = 5'd1;
                state_d = SCAN;
            end
            SCAN: begin
                raddr_s = {3'd0, idx_q};
                ctb_d   = ctb_q + {5'd0, inb_s};
                cto_d   = cto_q + {7'd0, (inb_s != 3'd0)};
                cts_d   = cts_q + {5'd0, inb_s} + {5'd0, crs_s};
                prev_d  = rdata_s;
                idx_d   = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = TAIL;
                end else begin
                    state_d = SCAN;
                end
            end
            TAIL: begin
                // Last byte has no successor, so no crossing windows
                ctb_d   = ctb_q + {5'd0, inb_s};
                cto_d   = cto_q + {7'd0, (inb_s != 3'd0)};
                cts_d   = cts_q + {5'd0, inb_s};
                state_d = WR33;
            end
            WR33: begin
                we_s    = 1'b1;
                waddr_s = 8'd33;
                wdata_s = ctb_q;
                state_d = WR34;
            end
            WR34: begin
                we_s    = 1'b1;
                waddr_s = 8'd34;
                wdata_s = cto_q;
                state_d = WR35;
            end
            WR35: begin
                we_s    = 1'b1;
                waddr_s = 8'd35;
                wdata_s = cts_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                done_d  = 1'b0;
                state_d = LOAD_PAT;
            end
        endcase
    end
endmodule

// File: tb/tb_pattern_count_top.sv
// Bench for pattern_count_top: fixed vectors, a mid-run reset abort and random
// messages checked against a bit-string reference model.

module tb_pattern_count_top;
    logic clk;
    logic reset;
    logic done;

    int total = 0;
    int bad   = 0;

    logic [7:0] img [0:255];

    typedef struct {
        string      name;
        logic [7:0] fill;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] patb;
        int         ctb;
        int         cto;
        int         cts;
    } vec_t;

    vec_t tbl [6];

    pattern_count_top dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: counts straight from the definitions over the bit string
    task automatic model(output int ctb, output int cto, output int cts);
        int pat;
        int hits;
        int val;
        pat = int'(img[32]) / 8;
        ctb = 0;
        cto = 0;
        cts = 0;
        for (int j = 0; j < 32; j++) begin
            hits = 0;
            for (int k = 0; k < 4; k++) begin
                if (((int'(img[j]) >> k) % 32) == pat) hits++;
            end
            ctb += hits;
            if (hits > 0) cto++;
        end
        for (int o = 0; o < 252; o++) begin
            val = 0;
            for (int t = 0; t < 5; t++) begin
                val = val * 2 + int'(img[(o + t) / 8][7 - ((o + t) % 8)]);
            end
            if (val == pat) cts++;
        end
    endtask

    // One complete run: load image under reset, optionally abort once, then check
    task automatic do_run(input string name, input int abort_at,
                          input int ectb, input int ecto, input int ects);
        int cyc;
        int diffs;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.dm1.core[i] = img[i];
        @(negedge clk);
        chk({name, "_done_in_reset"}, int'(done), 0);
        reset = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk({name, "_done_abort"}, int'(done), 0);
            reset = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, 37);
        chk({name, "_ctb"}, int'(dut.dm1.core[33]), ectb);
        chk({name, "_cto"}, int'(dut.dm1.core[34]), ecto);
        chk({name, "_cts"}, int'(dut.dm1.core[35]), ects);
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < 33 || i > 35) begin
                if (dut.dm1.core[i] !== img[i]) diffs++;
            end
        end
        chk({name, "_mem_preserved"}, diffs, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_held"}, int'(done), 1);
    endtask

    initial begin
        int ec;
        int eo;
        int es;
        int r;
        reset = 1'b1;

        tbl[0] = '{"aa_p10101", 8'hAA, 8'hAA, 8'hAA, 8'hA8, 64, 32, 126};
        tbl[1] = '{"aa_p01010", 8'hAA, 8'hAA, 8'hAA, 8'h50, 64, 32, 126};
        tbl[2] = '{"zero_p0",   8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
        tbl[3] = '{"zero_p1f",  8'h00, 8'h00, 8'h00, 8'hF8, 0, 0, 0};
        tbl[4] = '{"cross",     8'h00, 8'h03, 8'hE0, 8'hF8, 0, 0, 1};
        tbl[5] = '{"inbyte",    8'h00, 8'hF8, 8'h00, 8'hF8, 1, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", int'(done), 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 32; i++) img[i] = tbl[v].fill;
            img[0]  = tbl[v].b0;
            img[1]  = tbl[v].b1;
            img[32] = tbl[v].patb;
            do_run(tbl[v].name, 0, tbl[v].ctb, tbl[v].cto, tbl[v].cts);
        end

        // Abort ten cycles into a run; the restarted run must match the plain result
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++) img[i] = 8'hAA;
        img[32] = 8'hA8;
        do_run("abort", 10, 64, 32, 126);

        // Abort late, after some results have already been written
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
        img[32] = {img[7][6:2], 3'b101};
        model(ec, eo, es);
        do_run("abort_late", 36, ec, eo, es);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
            if (n % 2 == 0) begin
                r = $urandom_range(0, 31);
                img[32] = {img[r][5:1], 3'($urandom_range(0, 7))};
            end
            if (n == 3) begin
                for (int i = 0; i < 32; i++) img[i] = (i % 3 == 0) ? 8'h1F : 8'hF0;
            end
            model(ec, eo, es);
            do_run($sformatf("rand%0d", n), 0, ec, eo, es);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
